// File: rtl/ptwalker_pkg.sv
// Shared types and encodings for the hardware page-table walker.
package ptwalker_pkg;

  typedef enum logic [2:0] {IDLE, RD, CHK, WR, FILL, FAULT} statetype;

  typedef logic [1:0] level_t;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  localparam logic [3:0] SATP_SV32 = 4'd1;
  localparam logic [3:0] SATP_SV39 = 4'd8;
  localparam logic [3:0] SATP_SV48 = 4'd9;

  // Returns {supported, starting level} for a satp MODE value.
  function automatic logic [2:0] start_level(input logic [3:0] mode, input logic rv64);
    logic [2:0] r;
    r = 3'b000;
    if (rv64) begin
      if (mode == SATP_SV39)      r = 3'b110;
      else if (mode == SATP_SV48) r = 3'b111;
    end else if (mode == SATP_SV32) begin
      r = 3'b101;
    end
    return r;
  endfunction

endpackage

// File: rtl/ptwalker_pte_classify.sv
// Combinational PTE classification: invalid, leaf, misaligned superpage, A/D update needed.
module ptwalker_pte_classify
  import ptwalker_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pte,
  input  level_t          level,
  input  logic            write_access,
  output logic            invalid,
  output logic            leaf,
  output logic            misaligned,
  output logic            need_ad
);

  localparam int PPN_BITS = (XLEN == 64) ? 44 : 22;
  localparam int VPN_BITS = (XLEN == 64) ? 9 : 10;

  logic [PPN_BITS-1:0] ppn;
  logic [PPN_BITS-1:0] low_mask;
  logic                unused_pte;

  assign ppn      = pte[10 +: PPN_BITS];
  // PPN fields below the leaf level must be zero for a superpage.
  assign low_mask = ~({PPN_BITS{1'b1}} << (VPN_BITS * int'(level)));

  assign invalid    = ~pte[PTE_V] | (~pte[PTE_R] & pte[PTE_W]);
  assign leaf       = pte[PTE_R] | pte[PTE_X];
  assign misaligned = leaf & (|(ppn & low_mask));
  assign need_ad    = leaf & (~pte[PTE_A] | (write_access & ~pte[PTE_D]));

  assign unused_pte = ^pte;

endmodule

// File: rtl/ptwalker.sv
// Hardware page-table walker (TLB fill). Optional A/D writeback enabled by HPTW_ADUPDATE_EN.
//
//  state | meaning
//  IDLE  | waiting for a TLB miss
//  RD    | PTE read request outstanding
//  CHK   | classify registered PTE
//  WR    | A/D writeback outstanding (HPTW_ADUPDATE_EN only)
//  FILL  | one-cycle TLB write strobe
//  FAULT | one-cycle page fault strobe
module ptwalker
  import ptwalker_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int PA_BITS  = 56,
  parameter int MAXLEVEL = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    SATP_REGW,
  input  logic [XLEN-1:0]    VAdr,
  input  logic               TLBMiss,
  input  logic               TLBFlush,
  input  logic               WriteAccess,
  output logic               HPTWReq,
  output logic               HPTWWrite,
  output logic [PA_BITS-1:0] HPTWAdr,
  output logic [XLEN-1:0]    HPTWWriteData,
  input  logic               HPTWAck,
  input  logic [XLEN-1:0]    HPTWReadPTE,
  output logic [XLEN-1:0]    PTE,
  output logic [1:0]         PageTypeWriteVal,
  output logic               TLBWrite,
  output logic               DisableTranslation,
  output logic               HPTWPageFault,
  output logic               HPTWBusy
);

  localparam int PPN_BITS = (XLEN == 64) ? 44 : 22;
  localparam int VPN_BITS = (XLEN == 64) ? 9 : 10;
  localparam int OFS_BITS = (XLEN == 64) ? 3 : 2;
  localparam int ADR_BITS = PPN_BITS + VPN_BITS + OFS_BITS;

  statetype            state_q, state_d;
  level_t              level_q;
  logic [PPN_BITS-1:0] ppn_q;
  logic [XLEN-1:0]     pte_q;
  logic                flush_pend_q;

  logic [3:0]          satp_mode;
  logic [2:0]          start_info;
  logic                start_ok;
  logic                walk_start;
  logic [VPN_BITS-1:0] vpn;
  logic [ADR_BITS-1:0] adr_full;
  logic [XLEN-1:0]     wr_data;
  logic                invalid, leaf, misaligned, need_ad;
  logic                chk_fault;
  logic                unused_sig;

  assign satp_mode  = (XLEN == 64) ? SATP_REGW[XLEN-1 -: 4] : {3'b000, SATP_REGW[XLEN-1]};
  assign start_info = start_level(satp_mode, XLEN == 64);
  assign start_ok   = start_info[2] && (int'(start_info[1:0]) <= MAXLEVEL);
  assign walk_start = TLBMiss && !TLBFlush;

  assign vpn      = VPN_BITS'(VAdr >> (12 + VPN_BITS * int'(level_q)));
  assign adr_full = {ppn_q, vpn, {OFS_BITS{1'b0}}};
  assign wr_data  = pte_q | (XLEN'(1) << PTE_A) | (XLEN'(WriteAccess) << PTE_D);

  ptwalker_pte_classify #(.XLEN(XLEN)) u_classify (
    .pte          (pte_q),
    .level        (level_q),
    .write_access (WriteAccess),
    .invalid      (invalid),
    .leaf         (leaf),
    .misaligned   (misaligned),
    .need_ad      (need_ad)
  );

  assign chk_fault = invalid || (leaf && misaligned) || (!leaf && level_q == 2'd0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (walk_start) state_d = start_ok ? RD : FAULT;
      // A flush seen at any point of the read waits for the ack, then abandons the walk.
      RD:   if (HPTWAck) state_d = (flush_pend_q || TLBFlush) ? IDLE : CHK;
      CHK: begin
        if (TLBFlush)       state_d = IDLE;
        else if (chk_fault) state_d = FAULT;
        else if (!leaf)     state_d = RD;
`ifdef HPTW_ADUPDATE_EN
        else if (need_ad)   state_d = WR;
`endif
        else                state_d = FILL;
      end
`ifdef HPTW_ADUPDATE_EN
      WR:   if (HPTWAck) state_d = (flush_pend_q || TLBFlush) ? IDLE : FILL;
`else
      WR:   state_d = IDLE;
`endif
      FILL:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    HPTWReq       = 1'b0;
    HPTWWrite     = 1'b0;
    TLBWrite      = 1'b0;
    HPTWPageFault = 1'b0;
    unique case (state_q)
      RD: HPTWReq = 1'b1;
`ifdef HPTW_ADUPDATE_EN
      WR: begin
        HPTWReq   = 1'b1;
        HPTWWrite = 1'b1;
      end
`endif
      FILL:    TLBWrite      = ~TLBFlush;
      FAULT:   HPTWPageFault = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q      <= 2'd0;
      ppn_q        <= '0;
      pte_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          flush_pend_q <= 1'b0;
          if (walk_start) begin
            level_q <= start_info[1:0];
            ppn_q   <= SATP_REGW[PPN_BITS-1:0];
          end
        end
        RD, WR: begin
          if (TLBFlush) flush_pend_q <= 1'b1;
          if (HPTWAck) pte_q <= (state_q == WR) ? wr_data : HPTWReadPTE;
        end
        CHK: begin
          if (!chk_fault && !leaf) begin
            level_q <= level_q - 2'd1;
            ppn_q   <= pte_q[10 +: PPN_BITS];
          end
        end
        default: ;
      endcase
    end
  end

  assign HPTWBusy           = (state_q != IDLE);
  assign DisableTranslation = (state_q != IDLE);
  assign HPTWAdr            = HPTWReq ? PA_BITS'(adr_full) : '0;
  assign PTE                = (state_q == FILL) ? pte_q : '0;
  assign PageTypeWriteVal   = (state_q == FILL) ? level_q : 2'd0;
`ifdef HPTW_ADUPDATE_EN
  assign HPTWWriteData      = HPTWWrite ? wr_data : '0;
`else
  assign HPTWWriteData      = '0;
`endif

  assign unused_sig = ^{SATP_REGW, need_ad};

endmodule
